pipe_exec_ctrl: RTL
===================

Name: pipe_exec_ctrl

Overview:
Execution sequencer for the 5-stage MIPS32 pipeline; it sits beside the ID-stage control decoder and the debug/host interface.
- Gates global pipeline advance (o_pipe_en) and fetch (o_fetch_en).
- Implements run, single-step and stop commands.
- Detects the HALT opcode at fetch and drains the pipeline so HALT retires before freezing.
- Keeps a saturating count of executed cycles for the host.

Parameters:
CYCLE_CNT_W, 32, width of executed-cycle counter
PIPE_DEPTH, 5, pipeline stages; drain length is PIPE_DEPTH-1 enabled cycles
OPCODE_HALT, 6'b111111, opcode field value that terminates execution

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  host command strobe
i_cmd  in  2  00 CLEAR, 01 RUN, 10 STEP, 11 STOP
o_cmd_ready  out  1  command accepted when i_cmd_valid && o_cmd_ready at clock edge
i_if_opp  in  6  opcode of instruction currently in IF
i_stall  in  1  hazard/memory stall request; forces o_pipe_en low
o_pipe_en  out  1  all pipeline registers and PC advance when high
o_fetch_en  out  1  IF loads new instruction when high; low inserts NOP into IF/ID
o_pc_clear  out  1  one-cycle pulse: PC and pipeline registers clear
o_step_done  out  1  one-cycle pulse after a single step completes
o_halted  out  1  high in HALTED
o_busy  out  1  high in RUN, STEP, DRAIN
o_cycle_cnt  out  CYCLE_CNT_W  executed (o_pipe_en=1) cycles

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE; drain counter=0; o_cycle_cnt=0.
  - All outputs 0 except o_cmd_ready=1.
- States: IDLE, RUN, STEP, DRAIN, HALTED. Outputs are decoded from registered state; transitions on the rising edge.
- o_pipe_en = (state in RUN, STEP, DRAIN) && !i_stall.
- o_fetch_en = o_pipe_en && state!=DRAIN.
- o_cmd_ready = 1 in IDLE, RUN, HALTED; 0 in STEP and DRAIN.
- IDLE:
  - Accepted RUN -> RUN.
  - Accepted STEP -> STEP.
  - Accepted CLEAR -> o_pc_clear pulse, counter cleared, stay IDLE.
  - Accepted STOP is ignored.
- RUN:
  - If o_fetch_en && i_if_opp==OPCODE_HALT: the HALT is fetched this cycle; next state DRAIN, drain counter loaded with PIPE_DEPTH-1.
  - Else if STOP accepted -> IDLE. Other commands are accepted and ignored.
  - HALT detection has priority over a simultaneous STOP; the STOP is consumed and discarded.
- STEP:
  - Exactly one cycle with o_pipe_en=1. The state is held while i_stall=1.
  - On the enabled cycle: if HALT is fetched -> DRAIN; else -> IDLE with o_step_done=1 in the following cycle.
- DRAIN:
  - Fetch suppressed; NOPs enter IF/ID.
  - Counter decrements only on cycles with o_pipe_en=1.
  - When it decrements from 1 to 0 -> HALTED. Stalls lengthen the drain; they never shorten it.
- HALTED:
  - o_halted=1; pipeline frozen.
  - Only CLEAR has effect: o_pc_clear pulse, o_cycle_cnt cleared -> IDLE. RUN, STEP and STOP are accepted and ignored.
- o_cycle_cnt:
  - +1 on each cycle with o_pipe_en=1.
  - Saturates at all-ones; no wrap.
  - CLEAR has priority over increment.
- o_pc_clear and o_step_done are exactly one cycle wide and never asserted simultaneously.

Optional Feature:
- Macro PIPE_EXEC_CTRL_BREAKPOINT_EN.
- When defined, adds ports:
  - i_bp_valid in 1
  - i_bp_pc in 32
  - i_if_pc in 32
- In RUN, if i_bp_valid && i_if_pc==i_bp_pc && !i_stall:
  - o_pipe_en and o_fetch_en are forced 0 that cycle; the instruction is not fetched.
  - Next state IDLE.
- Breakpoint has priority over HALT detection and STOP in the same cycle.
- A subsequent STEP or RUN executes the breakpoint instruction. The breakpoint is ignored on the first enabled cycle after leaving IDLE, so RUN does not re-trap.
- When undefined: no extra ports; behaviour exactly as above.

Decomposition:
- Package pipe_exec_ctrl_pkg: state enum, 2-bit command encodings (CMD_CLEAR, CMD_RUN, CMD_STEP, CMD_STOP), default OPCODE_HALT.
- One natural sub-module, sat_counter: parameterised width, enable, sync clear, saturating. Used for o_cycle_cnt.
- Drain counter stays inline.

Test Plan:
- Reset: hold i_rst_n=0 mid-RUN -> all outputs 0, o_cmd_ready=1, o_cycle_cnt=0 immediately (asynchronous).
- RUN with HALT fetched at cycle 10, no stall:
  - o_pipe_en high for 10+4 cycles; o_fetch_en low for the last 4.
  - o_halted=1 afterwards; o_cycle_cnt=14.
- STEP while i_stall=1 for 3 cycles:
  - o_pipe_en stays 0 for 3 cycles, then 1 for one cycle.
  - o_step_done pulses the next cycle; o_cycle_cnt=1.
- HALT in RUN with i_stall high for 2 cycles during DRAIN -> DRAIN lasts 6 cycles; o_cycle_cnt counts only 4 of them.
- RUN with STOP and HALT opcode in the same cycle -> DRAIN entered, not IDLE.
- HALTED then CLEAR -> single o_pc_clear pulse, o_cycle_cnt=0, state IDLE. CYCLE_CNT_W=4 run of 20 cycles -> o_cycle_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_exec_ctrl_pkg.sv
// Shared types and encodings for the pipeline execution sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_exec_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   localparam logic [1:0] CMD_CLEAR = 2'b00;
   localparam logic [1:0] CMD_RUN   = 2'b01;
   localparam logic [1:0] CMD_STEP  = 2'b10;
   localparam logic [1:0] CMD_STOP  = 2'b11;

   localparam logic [5:0] DEFAULT_OPCODE_HALT = 6'b111111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: count visible one cycle after the enabled edge.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   // Count enabled cycles, stick at all-ones, clear on request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_exec_ctrl.sv
// Run/step/stop sequencer gating MIPS32 pipeline advance; drains on HALT fetch.
// Latency: enables decoded combinationally from registered state; pulses one cycle late.
// Backpressure: o_cmd_ready low in STEP/DRAIN; i_stall freezes the pipe. Optional PIPE_EXEC_CTRL_BREAKPOINT_EN.
module pipe_exec_ctrl
   import pipe_exec_ctrl_pkg::*;
#(
   parameter int          CYCLE_CNT_W = 32,
   parameter int          PIPE_DEPTH  = 5,
   parameter logic [5:0]  OPCODE_HALT = DEFAULT_OPCODE_HALT
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_cmd_valid,
   input  logic [1:0]             i_cmd,
   output logic                   o_cmd_ready,
   input  logic [5:0]             i_if_opp,
   input  logic                   i_stall,
`ifdef PIPE_EXEC_CTRL_BREAKPOINT_EN
   input  logic                   i_bp_valid,
   input  logic [31:0]            i_bp_pc,
   input  logic [31:0]            i_if_pc,
`endif
   output logic                   o_pipe_en,
   output logic                   o_fetch_en,
   output logic                   o_pc_clear,
   output logic                   o_step_done,
   output logic                   o_halted,
   output logic                   o_busy,
   output logic [CYCLE_CNT_W-1:0] o_cycle_cnt
);

   localparam int DRAIN_W = $clog2(PIPE_DEPTH) + 1;

   state_t               state;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic                 cmd_acc;
   logic                 halt_fetch;
   logic                 clr_acc;
   logic                 active;
   logic                 bp_hit;

   assign active      = (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
   assign o_cmd_ready = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_HALTED);
   assign o_pipe_en   = active && !i_stall && !bp_hit;
   assign o_fetch_en  = o_pipe_en && (state != ST_DRAIN);
   assign o_halted    = (state == ST_HALTED);
   assign o_busy      = active;
   assign cmd_acc     = i_cmd_valid && o_cmd_ready;
   assign halt_fetch  = o_fetch_en && (i_if_opp == OPCODE_HALT);
   assign clr_acc     = cmd_acc && (i_cmd == CMD_CLEAR)
                        && ((state == ST_IDLE) || (state == ST_HALTED));

`ifdef PIPE_EXEC_CTRL_BREAKPOINT_EN
   // Set when leaving IDLE so the trapped instruction can execute on resume.
   logic bp_skip;

   assign bp_hit = (state == ST_RUN) && i_bp_valid && (i_if_pc == i_bp_pc)
                   && !i_stall && !bp_skip;

   // Arm the skip on RUN/STEP from IDLE; drop it after the first enabled cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bp_skip <= 1'b0;
      end else if ((state == ST_IDLE) && cmd_acc
                   && ((i_cmd == CMD_RUN) || (i_cmd == CMD_STEP))) begin
         bp_skip <= 1'b1;
      end else if (o_pipe_en) begin
         bp_skip <= 1'b0;
      end
   end
`else
   assign bp_hit = 1'b0;
`endif

   // Sequencer FSM with the drain counter and the registered one-shot pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         drain_cnt   <= '0;
         o_pc_clear  <= 1'b0;
         o_step_done <= 1'b0;
      end else begin
         o_pc_clear  <= 1'b0;
         o_step_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_acc) begin
                  case (i_cmd)
                     CMD_RUN:   state <= ST_RUN;
                     CMD_STEP:  state <= ST_STEP;
                     CMD_CLEAR: o_pc_clear <= 1'b1;
                     default:   ;
                  endcase
               end
            end
            ST_RUN: begin
               // Breakpoint beats HALT, HALT beats a same-cycle STOP.
               if (bp_hit) begin
                  state <= ST_IDLE;
               end else if (halt_fetch) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRAIN_W'(PIPE_DEPTH - 1);
               end else if (cmd_acc && (i_cmd == CMD_STOP)) begin
                  state <= ST_IDLE;
               end
            end
            ST_STEP: begin
               if (o_pipe_en) begin
                  if (halt_fetch) begin
                     state     <= ST_DRAIN;
                     drain_cnt <= DRAIN_W'(PIPE_DEPTH - 1);
                  end else begin
                     state       <= ST_IDLE;
                     o_step_done <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               // Only enabled cycles move NOPs forward, so stalls stretch the drain.
               if (o_pipe_en) begin
                  drain_cnt <= drain_cnt - DRAIN_W'(1);
                  if (drain_cnt == DRAIN_W'(1)) begin
                     state <= ST_HALTED;
                  end
               end
            end
            ST_HALTED: begin
               if (cmd_acc && (i_cmd == CMD_CLEAR)) begin
                  state      <= ST_IDLE;
                  o_pc_clear <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   sat_counter #(
      .W (CYCLE_CNT_W)
   ) u_cycle_cnt (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (o_pipe_en),
      .clr   (clr_acc),
      .cnt   (o_cycle_cnt)
   );

endmodule
